// File: rtl/stg4ma_if.sv
// Pipeline-stage-4 bundle: upstream instruction fields, data-memory valid/ack port, downstream fields to stg5wb.
// slave = the stage itself; master = the surrounding pipeline/memory.
interface stg4ma_if #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 24,
  parameter int OPC_W    = 8,
  parameter int TGT_GP_W = 4,
  parameter int TGT_SR_W = 2
);
  logic [ADDR_W-1:0]   iw_pc;
  logic [DATA_W-1:0]   iw_instr;
  logic [OPC_W-1:0]    iw_opc;
  logic [TGT_GP_W-1:0] iw_tgt_gp;
  logic [TGT_SR_W-1:0] iw_tgt_sr;
  logic [DATA_W-1:0]   iw_result;
  logic [DATA_W-1:0]   iw_sdata;
  logic                ow_stall;

  logic                ow_mem_req;
  logic                ow_mem_we;
  logic [ADDR_W-1:0]   ow_mem_addr;
  logic [DATA_W-1:0]   ow_mem_wdata;
  logic                iw_mem_ack;
  logic [DATA_W-1:0]   iw_mem_rdata;

  logic [ADDR_W-1:0]   ow_pc;
  logic [DATA_W-1:0]   ow_instr;
  logic [OPC_W-1:0]    ow_opc;
  logic [TGT_GP_W-1:0] ow_tgt_gp;
  logic [TGT_SR_W-1:0] ow_tgt_sr;
  logic [DATA_W-1:0]   ow_result;
  logic                ow_fault;

  modport slave (
    input  iw_pc, iw_instr, iw_opc, iw_tgt_gp, iw_tgt_sr, iw_result, iw_sdata,
    input  iw_mem_ack, iw_mem_rdata,
    output ow_stall, ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
    output ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_sr, ow_result, ow_fault
  );

  modport master (
    output iw_pc, iw_instr, iw_opc, iw_tgt_gp, iw_tgt_sr, iw_result, iw_sdata,
    output iw_mem_ack, iw_mem_rdata,
    input  ow_stall, ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
    input  ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_sr, ow_result, ow_fault
  );
endinterface

// File: rtl/stg4ma.sv
// Memory-access stage: non-memory ops pass through in 1 cycle; LD/ST take >=2 cycles via a valid/ack memory port.
// While a transaction is open, ow_stall holds upstream and bubbles go downstream; a bounded timeout forces completion.
module stg4ma #(
  parameter int               ADDR_W   = 24,
  parameter int               DATA_W   = 24,
  parameter int               OPC_W    = 8,
  parameter int               TGT_GP_W = 4,
  parameter int               TGT_SR_W = 2,
  parameter logic [OPC_W-1:0] OPC_NOP  = '0,
  parameter logic [OPC_W-1:0] OPC_LD   = OPC_W'('h30),
  parameter logic [OPC_W-1:0] OPC_ST   = OPC_W'('h31),
  parameter int               TIMEOUT  = 1023,
  parameter int               CNT_W    = 16
) (
  input logic     iw_clk,
  input logic     iw_rst,
  stg4ma_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   instr;
    logic [OPC_W-1:0]    opc;
    logic [TGT_GP_W-1:0] tgt_gp;
    logic [TGT_SR_W-1:0] tgt_sr;
    logic [DATA_W-1:0]   result;
  } hdr_t;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  hdr_t              in_hdr, bubble;
  hdr_t              out_q, out_d;
  hdr_t              hold_q, hold_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_mem, ack_vld, timeout_hit;

  always_comb begin
    in_hdr        = '0;
    in_hdr.pc     = bus.iw_pc;
    in_hdr.instr  = bus.iw_instr;
    in_hdr.opc    = bus.iw_opc;
    in_hdr.tgt_gp = bus.iw_tgt_gp;
    in_hdr.tgt_sr = bus.iw_tgt_sr;
    in_hdr.result = bus.iw_result;
    bubble        = '0;
    bubble.opc    = OPC_NOP;
  end

  assign is_mem      = (bus.iw_opc == OPC_LD) || (bus.iw_opc == OPC_ST);
  // Ack only counts while a request is outstanding; stray acks are dropped.
  assign ack_vld     = bus.iw_mem_ack && req_q;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    out_d   = bubble;
    hold_d  = hold_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fault_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          hold_d  = in_hdr;
          req_d   = 1'b1;
          we_d    = (bus.iw_opc == OPC_ST);
          addr_d  = bus.iw_result[ADDR_W-1:0];
          wdata_d = bus.iw_sdata;
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          out_d = in_hdr;
        end
      end
      WAIT: begin
        if (ack_vld) begin
          req_d   = 1'b0;
          state_d = IDLE;
          out_d   = hold_q;
          if (hold_q.opc == OPC_LD) out_d.result = bus.iw_mem_rdata;
        end else if (timeout_hit) begin
          req_d        = 1'b0;
          state_d      = IDLE;
          out_d        = hold_q;
          out_d.result = '1;
          fault_d      = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q <= IDLE;
      out_q   <= bubble;
      hold_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hold_q  <= hold_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ow_stall     = (state_q == WAIT);
  assign bus.ow_mem_req   = req_q;
  assign bus.ow_mem_we    = we_q;
  assign bus.ow_mem_addr  = addr_q;
  assign bus.ow_mem_wdata = wdata_q;
  assign bus.ow_pc        = out_q.pc;
  assign bus.ow_instr     = out_q.instr;
  assign bus.ow_opc       = out_q.opc;
  assign bus.ow_tgt_gp    = out_q.tgt_gp;
  assign bus.ow_tgt_sr    = out_q.tgt_sr;
  assign bus.ow_result    = out_q.result;
  assign bus.ow_fault     = fault_q;

endmodule

// File: tb/tb_stg4ma.sv
// Bench for stg4ma: directed vector table, hand-written multi-cycle sequences, and a randomized stream
// scored against a transaction-level model (in-order outputs, latency -> ack or timeout).
module tb_stg4ma;
  localparam int AW = 24;
  localparam int DW = 24;
  localparam int TO = 4;
  localparam logic [7:0] LD = 8'h30;
  localparam logic [7:0] ST = 8'h31;

  logic iw_clk = 1'b0;
  logic iw_rst;
  always #5 iw_clk = ~iw_clk;

  stg4ma_if #(.ADDR_W(AW), .DATA_W(DW), .OPC_W(8), .TGT_GP_W(4), .TGT_SR_W(2)) bus ();

  stg4ma #(
    .ADDR_W(AW), .DATA_W(DW), .OPC_W(8), .TGT_GP_W(4), .TGT_SR_W(2),
    .OPC_NOP(8'h00), .OPC_LD(LD), .OPC_ST(ST), .TIMEOUT(TO), .CNT_W(16)
  ) dut (
    .iw_clk(iw_clk),
    .iw_rst(iw_rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic [7:0]    opc;
    logic [3:0]    gp;
    logic [1:0]    sr;
    logic [DW-1:0] res;
    logic [DW-1:0] sd;
  } ins_t;

  typedef struct {
    int            lat;
    logic [DW-1:0] rd;
  } mtx_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [7:0]    opc;
    logic [3:0]    gp;
    logic [1:0]    sr;
    logic [DW-1:0] res;
    logic          fault;
  } exp_t;

  mtx_t mq[$];
  exp_t expq[$];

  task automatic drive(input ins_t t);
    bus.iw_pc     = t.pc;
    bus.iw_instr  = t.instr;
    bus.iw_opc    = t.opc;
    bus.iw_tgt_gp = t.gp;
    bus.iw_tgt_sr = t.sr;
    bus.iw_result = t.res;
    bus.iw_sdata  = t.sd;
  endtask

  // Memory model: ack in the lat-th request cycle; random ack noise while no request is open.
  int            r_cnt = 0;
  int            r_lat = 0;
  logic [DW-1:0] r_rd;
  bit            in_txn    = 0;
  bit            aborted   = 0;
  bit            force_ack = 0;
  mtx_t          r_m;
  always @(negedge iw_clk) begin
    if (iw_rst && in_txn) aborted = 1;
    if (bus.ow_mem_req === 1'b1) begin
      if (!in_txn) begin
        in_txn  = 1;
        aborted = 0;
        r_cnt   = 0;
        if (mq.size() > 0) begin
          r_m   = mq.pop_front();
          r_lat = r_m.lat;
          r_rd  = r_m.rd;
        end else begin
          r_lat = 99;
          r_rd  = '0;
        end
      end
      r_cnt++;
      bus.iw_mem_ack   = (r_cnt == r_lat);
      bus.iw_mem_rdata = (r_cnt == r_lat) ? r_rd : DW'($urandom);
    end else begin
      if (in_txn) begin
        in_txn = 0;
        if (!aborted) chk("req_len", r_cnt, (r_lat <= TO) ? r_lat : TO);
      end
      bus.iw_mem_ack   = force_ack || ($urandom_range(0, 2) == 0);
      bus.iw_mem_rdata = DW'($urandom);
    end
  end

  typedef struct {
    ins_t          in;
    int            lat;
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_res;
    logic          exp_fault;
    int            exp_edges;
  } vec_t;

  vec_t vt[7];
  ins_t filler, cur, ia, ib;
  int   n, stall_n, gen, cyc, cur_lat;
  bit   got, mem, have, stall_seen;
  logic [DW-1:0] cur_rd;
  exp_t e;
  int   bb_req[7];
  logic [7:0]    bb_opc[7];
  logic [DW-1:0] bb_res[7];

  task automatic rand_ins(output ins_t t, output int lat, output logic [DW-1:0] rd);
    int k;
    k        = $urandom_range(0, 9);
    t.pc     = AW'($urandom);
    t.instr  = DW'($urandom);
    t.opc    = (k < 4) ? LD : (k < 6) ? ST : 8'($urandom_range(1, 8'h2F));
    t.gp     = 4'($urandom);
    t.sr     = 2'($urandom);
    t.res    = DW'($urandom);
    t.sd     = DW'($urandom);
    lat      = $urandom_range(1, 6);
    rd       = DW'($urandom);
  endtask

  initial begin
    filler = '{pc: '0, instr: '0, opc: 8'h00, gp: '0, sr: '0, res: '0, sd: '0};
    vt[0] = '{in: '{24'h000100, 24'h0A0B0C, 8'h02, 4'd3, 2'd1, 24'h000123, 24'h0}, lat: 0, rd: 24'h0,
              exp_res: 24'h000123, exp_fault: 1'b0, exp_edges: 1};
    vt[1] = '{in: '{24'h000104, 24'h300040, LD, 4'd7, 2'd0, 24'h000040, 24'h0}, lat: 3, rd: 24'h00BEEF,
              exp_res: 24'h00BEEF, exp_fault: 1'b0, exp_edges: 4};
    vt[2] = '{in: '{24'h000108, 24'h310010, ST, 4'd2, 2'd2, 24'h000010, 24'h0000AA}, lat: 1, rd: 24'h0,
              exp_res: 24'h000010, exp_fault: 1'b0, exp_edges: 2};
    vt[3] = '{in: '{24'h00010C, 24'h300050, LD, 4'd4, 2'd3, 24'h000050, 24'h0}, lat: 99, rd: 24'h0,
              exp_res: 24'hFFFFFF, exp_fault: 1'b1, exp_edges: 5};
    vt[4] = '{in: '{24'h000110, 24'h310020, ST, 4'd1, 2'd0, 24'h000020, 24'h000055}, lat: 4, rd: 24'h0,
              exp_res: 24'h000020, exp_fault: 1'b0, exp_edges: 5};
    vt[5] = '{in: '{24'h000114, 24'h300060, LD, 4'd9, 2'd1, 24'h000060, 24'h0}, lat: 5, rd: 24'h00CAFE,
              exp_res: 24'hFFFFFF, exp_fault: 1'b1, exp_edges: 5};
    vt[6] = '{in: '{24'h000118, 24'h2F0000, 8'h2F, 4'd15, 2'd3, 24'hABCDEF, 24'h0}, lat: 0, rd: 24'h0,
              exp_res: 24'hABCDEF, exp_fault: 1'b0, exp_edges: 1};

    // Reset state
    drive(filler);
    iw_rst = 1'b1;
    repeat (2) @(posedge iw_clk);
    #1;
    chk("rst_opc", bus.ow_opc, 8'h00);
    chk("rst_stall", bus.ow_stall, 1'b0);
    chk("rst_req", bus.ow_mem_req, 1'b0);
    chk("rst_fault", bus.ow_fault, 1'b0);
    chk("rst_result", bus.ow_result, 24'h0);
    iw_rst = 1'b0;
    @(posedge iw_clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      mem = (vt[i].in.opc == LD) || (vt[i].in.opc == ST);
      if (mem) mq.push_back('{vt[i].lat, vt[i].rd});
      drive(vt[i].in);
      n = 0; got = 0; stall_n = 0;
      while (!got && n < 20) begin
        @(posedge iw_clk);
        #1;
        n++;
        if (n == 1) begin
          drive(filler);
          if (mem) begin
            chk("cap_req", bus.ow_mem_req, 1'b1);
            chk("cap_stall", bus.ow_stall, 1'b1);
            chk("cap_we", bus.ow_mem_we, vt[i].in.opc == ST);
            chk("cap_addr", bus.ow_mem_addr, vt[i].in.res);
            chk("cap_wdata", bus.ow_mem_wdata, vt[i].in.sd);
          end else begin
            chk("pass_req", bus.ow_mem_req, 1'b0);
          end
        end
        if (bus.ow_opc != 8'h00) got = 1;
        else if (bus.ow_stall) stall_n++;
      end
      chk("vec_out_seen", got, 1'b1);
      chk("vec_latency", n, vt[i].exp_edges);
      chk("vec_stall_cycles", stall_n, vt[i].exp_edges - 1);
      chk("vec_opc", bus.ow_opc, vt[i].in.opc);
      chk("vec_pc", bus.ow_pc, vt[i].in.pc);
      chk("vec_gp", bus.ow_tgt_gp, vt[i].in.gp);
      chk("vec_result", bus.ow_result, vt[i].exp_res);
      chk("vec_fault", bus.ow_fault, vt[i].exp_fault);
      @(posedge iw_clk);
      #1;
      chk("post_fault", bus.ow_fault, 1'b0);
      chk("post_req", bus.ow_mem_req, 1'b0);
      chk("post_opc", bus.ow_opc, 8'h00);
    end

    // Back-to-back LD, LD: request gap and in-order delivery
    ia = '{24'h000200, 24'h300080, LD, 4'd5, 2'd1, 24'h000080, 24'h0};
    ib = '{24'h000204, 24'h300090, LD, 4'd9, 2'd2, 24'h000090, 24'h0};
    mq.push_back('{2, 24'h000111});
    mq.push_back('{1, 24'h000222});
    bb_req = '{1, 1, 0, 1, 0, 0, 0};
    bb_opc = '{8'h00, 8'h00, LD, 8'h00, LD, 8'h00, 8'h00};
    bb_res = '{24'h0, 24'h0, 24'h000111, 24'h0, 24'h000222, 24'h0, 24'h0};
    drive(ia);
    for (int s = 0; s < 7; s++) begin
      @(posedge iw_clk);
      #1;
      if (s == 0) drive(ib);
      if (s == 3) drive(filler);
      chk("b2b_req", bus.ow_mem_req, bb_req[s]);
      chk("b2b_opc", bus.ow_opc, bb_opc[s]);
      chk("b2b_result", bus.ow_result, bb_res[s]);
      if (s == 2) chk("b2b_gp_a", bus.ow_tgt_gp, 4'd5);
      if (s == 4) chk("b2b_gp_b", bus.ow_tgt_gp, 4'd9);
    end

    // Reset in the second WAIT cycle abandons the transaction
    mq.push_back('{99, 24'h0});
    drive(ia);
    @(posedge iw_clk);
    #1;
    drive(filler);
    @(posedge iw_clk);
    #1;
    chk("pre_rst_stall", bus.ow_stall, 1'b1);
    iw_rst = 1'b1;
    @(posedge iw_clk);
    #1;
    iw_rst = 1'b0;
    chk("midrst_req", bus.ow_mem_req, 1'b0);
    chk("midrst_stall", bus.ow_stall, 1'b0);
    chk("midrst_opc", bus.ow_opc, 8'h00);
    chk("midrst_fault", bus.ow_fault, 1'b0);
    force_ack = 1;
    for (int s = 0; s < 5; s++) begin
      @(posedge iw_clk);
      #1;
      chk("late_ack_opc", bus.ow_opc, 8'h00);
      chk("late_ack_req", bus.ow_mem_req, 1'b0);
    end
    force_ack = 0;

    // Randomized stream against the transaction-level model
    rand_ins(cur, cur_lat, cur_rd);
    drive(cur);
    have = 1; gen = 1; cyc = 0;
    stall_seen = bus.ow_stall;
    while (cyc < 20000 && !(gen >= 300 && !have && expq.size() == 0)) begin
      @(posedge iw_clk);
      #1;
      cyc++;
      if (!stall_seen && have) begin
        e.pc = cur.pc; e.opc = cur.opc; e.gp = cur.gp; e.sr = cur.sr;
        e.fault = 1'b0; e.res = cur.res;
        if (cur.opc == LD || cur.opc == ST) begin
          mq.push_back('{cur_lat, cur_rd});
          e.fault = (cur_lat > TO);
          if (e.fault) e.res = '1;
          else if (cur.opc == LD) e.res = cur_rd;
        end
        expq.push_back(e);
        if (gen < 300) begin
          rand_ins(cur, cur_lat, cur_rd);
          drive(cur);
          gen++;
        end else begin
          drive(filler);
          have = 0;
        end
      end
      if (bus.ow_opc != 8'h00) begin
        if (expq.size() == 0) begin
          chk("rnd_unexpected_out", bus.ow_opc, 8'h00);
        end else begin
          e = expq.pop_front();
          chk("rnd_opc", bus.ow_opc, e.opc);
          chk("rnd_pc", bus.ow_pc, e.pc);
          chk("rnd_gp", bus.ow_tgt_gp, e.gp);
          chk("rnd_sr", bus.ow_tgt_sr, e.sr);
          chk("rnd_result", bus.ow_result, e.res);
          chk("rnd_fault", bus.ow_fault, e.fault);
        end
      end else begin
        chk("rnd_bubble_fault", bus.ow_fault, 1'b0);
      end
      stall_seen = bus.ow_stall;
    end
    chk("rnd_drain", expq.size(), 0);
    chk("rnd_all_issued", gen, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
